// File: rtl/delay_ctrl_pkg.sv
// Shared widths, state encoding and helpers for the delay-RAM sequencing controller.
package delay_ctrl_pkg;

   localparam int DELAY_DATA_WIDTH  = 16;
   localparam int DELAY_ADDR_WIDTH  = 3;
   localparam int DELAY_DEPTH       = 8;
   localparam int DELAY_STATE_WIDTH = 3;

   typedef enum logic [DELAY_STATE_WIDTH-1:0] {
      DLY_IDLE = 3'd0,
      DLY_RD   = 3'd1,
      DLY_WS   = 3'd2,
      DLY_WP   = 3'd3,
      DLY_WH   = 3'd4,
      DLY_OUT  = 3'd5
   } dly_state_e;

   // The controller owns mem_data only while a write is being set up, pulsed or held.
   function automatic logic drives_bus(input dly_state_e s);
      return (s == DLY_WS) || (s == DLY_WP) || (s == DLY_WH);
   endfunction

endpackage

// File: rtl/delay_ctrl_if.sv
// Sample-stream handshakes plus RAM control lines between the controller and its environment.
interface delay_ctrl_if #(
   parameter int DATA_WIDTH = delay_ctrl_pkg::DELAY_DATA_WIDTH,
   parameter int ADDR_WIDTH = delay_ctrl_pkg::DELAY_ADDR_WIDTH
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [ADDR_WIDTH-1:0] delay;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic                  mem_oe;

   modport master (
      output in_valid, in_data, delay, out_ready,
      input  in_ready, out_valid, out_data, mem_addr, mem_we, mem_oe
   );

   modport slave (
      input  in_valid, in_data, delay, out_ready,
      output in_ready, out_valid, out_data, mem_addr, mem_we, mem_oe
   );
endinterface

// File: rtl/delay_ptr.sv
// Circular-buffer bookkeeping: write pointer, fill level, modulo-DEPTH read address
// and the flag telling whether the requested tap has ever been written.
module delay_ptr #(
   parameter int ADDR_WIDTH = delay_ctrl_pkg::DELAY_ADDR_WIDTH,
   parameter int DEPTH      = delay_ctrl_pkg::DELAY_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  adv_i,
   input  logic [ADDR_WIDTH-1:0] dly_i,
   output logic [ADDR_WIDTH-1:0] wptr_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  unwritten_o
);

   localparam int FW = $clog2(DEPTH + 1);
   localparam int CW = FW + ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
   localparam logic [FW-1:0]         FULL    = FW'(DEPTH);

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [FW-1:0]         fill_q, fill_d;

   // The wrapped result is always below DEPTH, so modulo-2^ADDR_WIDTH arithmetic is exact.
   always_comb begin
      if (wptr_q >= dly_i) begin
         rd_addr_o = wptr_q - dly_i;
      end else begin
         rd_addr_o = wptr_q + DEPTH_A - dly_i;
      end
      unwritten_o = CW'(dly_i) > CW'(fill_q);
   end

   always_comb begin
      wptr_d = wptr_q;
      fill_d = fill_q;
      if (adv_i) begin
         wptr_d = (wptr_q == LAST) ? '0 : wptr_q + ADDR_WIDTH'(1);
         if (fill_q != FULL) begin
            fill_d = fill_q + FW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         fill_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         fill_q <= fill_d;
      end
   end

   assign wptr_o = wptr_q;

endmodule

// File: rtl/delay_ctrl.sv
// Delay-line sequencer: one read then a setup/pulse/hold write per sample over a
// single-port async RAM, presenting each input sample back delayed by dly_q samples.
//
//  state | meaning
//  IDLE  | ready for next input sample
//  RD    | OE asserted at the read tap, data captured into rd_q
//  WS    | write setup: address and data driven, WE low
//  WP    | write pulse: WE high
//  WH    | write hold: WE low, data still driven; pointer/fill advance on exit
//  OUT   | delayed sample presented until out_ready
module delay_ctrl
   import delay_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DELAY_DATA_WIDTH,
   parameter int ADDR_WIDTH = DELAY_ADDR_WIDTH,
   parameter int DEPTH      = DELAY_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   delay_ctrl_if.slave           bus,
   inout  wire  [DATA_WIDTH-1:0] mem_data
);

   localparam logic [ADDR_WIDTH-1:0] MAX_DLY = ADDR_WIDTH'(DEPTH - 1);

   dly_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] wr_q, wr_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic [ADDR_WIDTH-1:0] dly_q, dly_d;
   logic [ADDR_WIDTH-1:0] dly_in;
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  unwritten;
   logic                  adv;

   delay_ptr #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ptr (
      .clk         (clk),
      .rst_n       (rst_n),
      .adv_i       (adv),
      .dly_i       (dly_q),
      .wptr_o      (wptr),
      .rd_addr_o   (rd_addr),
      .unwritten_o (unwritten)
   );

   assign dly_in = ({1'b0, bus.delay} > {1'b0, MAX_DLY}) ? MAX_DLY : bus.delay;
   assign adv    = (state_q == DLY_WH);

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      out_d   = out_q;
      dly_d   = dly_q;
      case (state_q)
         DLY_IDLE: begin
            if (bus.in_valid) begin
               wr_d    = bus.in_data;
               dly_d   = dly_in;
               state_d = DLY_RD;
            end
         end
         DLY_RD: begin
            rd_d    = mem_data;
            state_d = DLY_WS;
         end
         DLY_WS:  state_d = DLY_WP;
         DLY_WP:  state_d = DLY_WH;
         // Select here, while fill still reflects the state before this sample's write.
         DLY_WH: begin
            if (dly_q == '0) begin
               out_d = wr_q;
            end else if (unwritten) begin
               out_d = '0;
            end else begin
               out_d = rd_q;
            end
            state_d = DLY_OUT;
         end
         DLY_OUT: begin
            if (bus.out_ready) begin
               state_d = DLY_IDLE;
            end
         end
         default: state_d = DLY_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DLY_IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         out_q   <= '0;
         dly_q   <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         out_q   <= out_d;
         dly_q   <= dly_d;
      end
   end

   // RAM strobes decode straight from state so an async reset releases them at once.
   assign bus.in_ready  = rst_n && (state_q == DLY_IDLE);
   assign bus.out_valid = (state_q == DLY_OUT);
   assign bus.out_data  = (state_q == DLY_OUT) ? out_q : '0;
   assign bus.mem_oe    = (state_q == DLY_RD);
   assign bus.mem_we    = (state_q == DLY_WP);
   assign bus.mem_addr  = (state_q == DLY_RD)  ? rd_addr :
                          drives_bus(state_q)  ? wptr    : '0;

   assign mem_data = drives_bus(state_q) ? wr_q : 'z;

endmodule

// File: doc/delay_ctrl.md
# delay_ctrl

Sequencing controller for the single-port asynchronous delay RAM. It turns a stream of audio samples into the same stream delayed by a programmable number of samples, implementing a circular buffer over the RAM. The controller owns the RAM's address, bidirectional data, WE and OE lines, and sits between the per-channel sample source and the mixer. It also guarantees the RAM never sees WE and OE active together and never sees a bus contention.

## Interface
- `DATA_WIDTH`, default `` `DelayDataWidth ``: sample width in bits.
- `ADDR_WIDTH`, default `` `DelayAddrWidth ``: RAM address width.
- `DEPTH`, default `` `DelayDepth ``: number of RAM words; need not be a power of two.

- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: input sample offered.
- `in_ready`, output, 1: controller accepts an input sample.
- `in_data`, input, DATA_WIDTH: input sample.
- `delay`, input, ADDR_WIDTH: requested delay in samples; sampled on input acceptance.
- `out_valid`, output, 1: delayed sample available.
- `out_ready`, input, 1: downstream accepts the output sample.
- `out_data`, output, DATA_WIDTH: delayed sample.
- `mem_addr`, output, ADDR_WIDTH: RAM address.
- `mem_data`, inout, DATA_WIDTH: RAM data bus; driven only in write states, otherwise `'bz`.
- `mem_we`, output, 1: RAM write enable.
- `mem_oe`, output, 1: RAM output enable.

## Operation
- **State machine:** `IDLE → RD → WS → WP → WH → OUT → IDLE`.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid&&in_ready`: latch `in_data` into `wr_q` and `min(delay, DEPTH-1)` into `dly_q`, then go to RD.
- **RD:**
  - `mem_oe=1`, `mem_addr=rd_addr`.
  - At the end of the cycle, capture `mem_data` into `rd_q`.
- **WS (write setup):** `mem_addr=wptr`, drive `mem_data=wr_q`, `mem_we=0`.
- **WP (write pulse):** same address and data, `mem_we=1`.
- **WH (write hold):**
  - Same address and data, `mem_we=0`.
  - On exit: `wptr` advances, and `fill` increments, saturating at DEPTH.
- **OUT:**
  - `out_valid=1`.
  - Hold `out_data` stable until `out_ready` is high at a clock edge, then go to IDLE.
- **Read address:** `rd_addr = (wptr >= dly_q) ? wptr-dly_q : wptr+DEPTH-dly_q`.
- **Write pointer wrap:** `wptr` goes from `DEPTH-1` to 0.
- **Output selection:**
  - `dly_q==0`: `out_data = wr_q` (bypass). The RD cycle still runs, so latency is constant.
  - `dly_q > fill` (location never written): `out_data = 0`. Uninitialised RAM content is never forwarded.
  - Otherwise: `out_data = rd_q`.
- **Delay changes:** only affect the next accepted sample. No slewing or interpolation.
- **Bus invariants:**
  - `mem_we && mem_oe` is never 1.
  - `mem_data` is driven only in WS, WP and WH.
  - `mem_oe` is 1 only in RD.

## Timing
- **Reset (async, any state):**
  - State goes to IDLE.
  - Outputs: `in_ready=0` while `rst_n=0`, then 1. `out_valid=0`, `out_data=0`, `mem_we=0`, `mem_oe=0`, `mem_addr=0`, `mem_data='bz`.
  - Registers: `wptr=0`, `fill=0`, `wr_q=rd_q=dly_q=0`.
  - A transaction in flight is dropped, and a write in progress is aborted immediately.
- **Latency:** acceptance at edge E puts RD in cycle E+1. WS, WP and WH follow. `out_valid` rises in cycle E+5.
- **Throughput:** at most one sample per 6 cycles when `out_ready` is held high. `in_ready` is 0 from RD through OUT.
- **Backpressure:** with `out_ready=0`, OUT is held indefinitely. `out_data` is stable, and no RAM access occurs.
- **`fill` and `wptr`:** updated only on the WH→OUT transition.
- **Wrap-around:** with `wptr=DEPTH-1` and `dly_q=DEPTH-1`, `rd_addr=0`.

## Structure
- The following go in `src/parameters.v`, next to the existing delay width/depth macros:
  - state encodings `` `DlyIdle ``, `` `DlyRd ``, `` `DlyWs ``, `` `DlyWp ``, `` `DlyWh ``, `` `DlyOut `` (3 bits);
  - `` `DelayStateWidth ``.
- One sub-module, `delay_ptr`, is natural. It holds `wptr` and `fill`, computes the modulo-DEPTH read address, and produces the "unwritten" flag. It is combinational except for the two registers.
- The tri-state driver on `mem_data` stays in `delay_ctrl`.

## Test plan
The bench uses DEPTH=8, DATA_WIDTH=16 and the RAM model attached.
- **Fill and delay:** with `delay=3`, feed 1, 2, … 10 with `out_ready=1` → outputs are 0, 0, 0, 1, 2, … 7. No X on `out_data`.
- **Bypass:** with `delay=0`, feed `0xAAAA`, `0x5555` → outputs are `0xAAAA`, `0x5555`, each 5 cycles after acceptance.
- **Wrap-around:** with `delay=7`, feed 1..20 → output n equals input n-7 for n>7. `mem_addr` wraps from 7 to 0 on writes.
- **Backpressure:** hold `out_ready=0` for 10 cycles in OUT → `out_valid` and `out_data` are stable, `in_ready=0`, `mem_we=mem_oe=0`. Release → back to IDLE the next cycle.
- **Reset mid-write:** assert `rst_n=0` during WP → `mem_we` drops in the same cycle and `mem_data` goes to Z. After release, with `delay=2`, feed 9, 8, 7 → outputs 0, 0, 9.
- **Bus assertion:** over all scenarios, `mem_we&&mem_oe` is never 1, and `mem_data` is not driven by the controller while `mem_oe=1`.
